// File: rtl/apb_req_master.sv
// APB requester: turns a valid/ready request into one APB transfer and returns a response.
// Latency: 3 cycles request-accept to rsp_valid_o for a zero-wait slave, +1 per wait state.
// Backpressure: req_ready_o only in IDLE; the response is held until rsp_ready_i is seen.
module apb_req_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          pclk_i,
    input  logic                          preset_i,
    // request channel
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [ADDR_WIDTH-1:0]         req_addr_i,
    input  logic                          req_write_i,
    input  logic [DATA_WIDTH-1:0]         req_wdata_i,
    input  logic [(DATA_WIDTH+7)/8-1:0]   req_strb_i,
    // response channel
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic                          rsp_err_o,
    // APB requester side
    output logic [ADDR_WIDTH-1:0]         paddr_o,
    output logic                          psel_o,
    output logic                          penable_o,
    output logic                          pwrite_o,
    output logic [DATA_WIDTH-1:0]         pwdata_o,
    output logic [(DATA_WIDTH+7)/8-1:0]   pstrb_o,
    output logic [2:0]                    pprot_o,
    input  logic                          pready_i,
    input  logic [DATA_WIDTH-1:0]         prdata_i,
    input  logic                          pslverr_i
);

    localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8;
    // Counter only needs to reach TIMEOUT_CYCLES; keep one bit when the timeout is disabled.
    localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] TO_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    psel_q;
    logic                    penable_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic                    pwrite_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [STRB_WIDTH-1:0]   pstrb_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic [CNT_WIDTH-1:0]    cnt_q;

    logic [CNT_WIDTH-1:0]    cnt_d;
    logic                    abort_d;

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign paddr_o     = paddr_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign pwdata_o    = pwdata_q;
    assign pstrb_o     = pstrb_q;
    assign pprot_o     = 3'b000;

    // Wait-cycle counter increment (saturating) and timeout abort decision for the ACCESS phase.
    always_comb begin
        cnt_d   = (cnt_q == TO_VAL) ? cnt_q : cnt_q + 1'b1;
        abort_d = (TIMEOUT_CYCLES > 0) && (cnt_q == TO_VAL) && !pready_i;
    end

    // Transfer FSM with all APB and response outputs registered.
    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        state_q   <= SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        paddr_q   <= req_addr_i;
                        pwrite_q  <= req_write_i;
                        // Reads present zero data and strobes on the bus.
                        pwdata_q  <= req_write_i ? req_wdata_i : '0;
                        pstrb_q   <= req_write_i ? req_strb_i  : '0;
                        cnt_q     <= '0;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (pready_i) begin
                        state_q     <= RESP;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= pslverr_i;
                        rsp_rdata_q <= (!pwrite_q && !pslverr_i) ? prdata_i : '0;
                    end else if (abort_d) begin
                        state_q     <= RESP;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    // Going straight to IDLE means no request is taken in the handshake cycle.
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_master.sv
module tb_apb_req_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    apb_req_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pclk_i      (clk),
        .preset_i    (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_write_i (req_write),
        .req_wdata_i (req_wdata),
        .req_strb_i  (req_strb),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .paddr_o     (paddr),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .pwdata_o    (pwdata),
        .pstrb_o     (pstrb),
        .pprot_o     (pprot),
        .pready_i    (pready),
        .prdata_i    (prdata),
        .pslverr_i   (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Response monitor: samples just after the negedge, once the bench has driven rsp_ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_rsp: got rdata 0x%0h err %0d with no response expected", rsp_rdata, rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", {32'h0, rsp_rdata}, {32'h0, e.rdata});
                    chk("rsp_err", {63'h0, rsp_err}, {63'h0, e.err});
                end
            end
        end
    end

    // One complete transfer; the slave inserts `waits` low-pready ACCESS cycles.
    task automatic do_xfer(input string nm, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wd, input logic [3:0] st, input int waits,
                           input logic [31:0] rd, input logic err);
        logic [31:0] exp_wd;
        logic [3:0]  exp_st;
        exp_t        e;
        exp_wd  = wr ? wd : 32'h0;
        exp_st  = wr ? st : 4'h0;
        e.rdata = (wr || err) ? 32'h0 : rd;
        e.err   = err;
        @(negedge clk); // cycle 0: IDLE
        chk({nm, "_req_ready_idle"}, {63'h0, req_ready}, 64'h1);
        chk({nm, "_psel_idle"}, {63'h0, psel}, 64'h0);
        exp_q.push_back(e);
        req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd; req_strb = st;
        // Slave signals active outside ACCESS must be ignored.
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF_FFFF;
        @(negedge clk); // cycle 1: SETUP
        req_valid = 1'b0; req_addr = 32'hFFFF_FFF0; req_write = ~wr;
        req_wdata = 32'hA5A5_A5A5; req_strb = 4'h5;
        chk({nm, "_setup_psel"}, {63'h0, psel}, 64'h1);
        chk({nm, "_setup_penable"}, {63'h0, penable}, 64'h0);
        chk({nm, "_setup_paddr"}, {32'h0, paddr}, {32'h0, addr});
        chk({nm, "_setup_pwrite"}, {63'h0, pwrite}, {63'h0, wr});
        chk({nm, "_setup_pwdata"}, {32'h0, pwdata}, {32'h0, exp_wd});
        chk({nm, "_setup_pstrb"}, {60'h0, pstrb}, {60'h0, exp_st});
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk); // ACCESS
            chk({nm, "_access_psel"}, {63'h0, psel}, 64'h1);
            chk({nm, "_access_penable"}, {63'h0, penable}, 64'h1);
            chk({nm, "_access_paddr"}, {32'h0, paddr}, {32'h0, addr});
            chk({nm, "_access_pwdata"}, {32'h0, pwdata}, {32'h0, exp_wd});
            chk({nm, "_access_pstrb"}, {60'h0, pstrb}, {60'h0, exp_st});
            pready  = (k == waits);
            prdata  = (k == waits) ? rd : 32'hDEAD_0000 + 32'(k);
            pslverr = (k == waits) ? err : 1'b1;
        end
        @(negedge clk); // RESP at cycle 3 + waits
        pready = 1'b0; pslverr = 1'b0;
        chk({nm, "_resp_valid"}, {63'h0, rsp_valid}, 64'h1);
        chk({nm, "_resp_psel"}, {63'h0, psel}, 64'h0);
        chk({nm, "_resp_penable"}, {63'h0, penable}, 64'h0);
        chk({nm, "_resp_req_ready"}, {63'h0, req_ready}, 64'h0);
        chk({nm, "_resp_paddr_kept"}, {32'h0, paddr}, {32'h0, addr});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_write = 1'b0;
        req_wdata = 32'h0; req_strb = 4'h0; rsp_ready = 1'b1;
        pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_psel", {63'h0, psel}, 64'h0);
        chk("rst_penable", {63'h0, penable}, 64'h0);
        chk("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("rst_rsp_err", {63'h0, rsp_err}, 64'h0);
        chk("rst_rsp_rdata", {32'h0, rsp_rdata}, 64'h0);
        chk("rst_paddr", {32'h0, paddr}, 64'h0);
        chk("rst_pwrite", {63'h0, pwrite}, 64'h0);
        chk("rst_pwdata", {32'h0, pwdata}, 64'h0);
        chk("rst_pstrb", {60'h0, pstrb}, 64'h0);
        chk("rst_pprot", {61'h0, pprot}, 64'h0);
        chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
        rst = 1'b0;

        // Zero-wait write, 3-wait read, slave error on read.
        do_xfer("wr0", 32'h0003_0000, 1'b1, 32'h0000_1234, 4'hF, 0, 32'h0, 1'b0);
        do_xfer("rd3", 32'h0003_0004, 1'b0, 32'h0, 4'h0, 3, 32'h0000_BEEF, 1'b0);
        do_xfer("rderr", 32'h0003_0008, 1'b0, 32'h0, 4'h0, 0, 32'h0000_7777, 1'b1);

        // Timeout with TIMEOUT_CYCLES=4: four counted wait cycles, abort on the fifth.
        begin
            exp_t e;
            e.rdata = 32'h0; e.err = 1'b1;
            @(negedge clk);
            chk("to_req_ready", {63'h0, req_ready}, 64'h1);
            exp_q.push_back(e);
            req_valid = 1'b1; req_addr = 32'h0004_0000; req_write = 1'b0;
            pready = 1'b0; prdata = 32'h0000_1111;
            @(negedge clk);
            req_valid = 1'b0;
            chk("to_setup_psel", {63'h0, psel}, 64'h1);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk("to_access_psel", {63'h0, psel}, 64'h1);
                chk("to_access_penable", {63'h0, penable}, 64'h1);
            end
            @(negedge clk);
            chk("to_resp_valid", {63'h0, rsp_valid}, 64'h1);
            chk("to_resp_psel", {63'h0, psel}, 64'h0);
            chk("to_resp_penable", {63'h0, penable}, 64'h0);
            repeat (2) begin
                @(negedge clk);
                chk("to_after_psel", {63'h0, psel}, 64'h0);
            end
        end

        // Response backpressure: 5 cycles of rsp_ready low while a new request waits.
        rsp_ready = 1'b0;
        do_xfer("bp", 32'h0005_0000, 1'b0, 32'h0, 4'h0, 0, 32'h0000_CAFE, 1'b0);
        req_valid = 1'b1; req_addr = 32'h0006_0000; req_write = 1'b1;
        req_wdata = 32'h0000_9876; req_strb = 4'hC;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", {63'h0, rsp_valid}, 64'h1);
            chk("bp_rsp_rdata", {32'h0, rsp_rdata}, 64'h0000_CAFE);
            chk("bp_rsp_err", {63'h0, rsp_err}, 64'h0);
            chk("bp_req_ready", {63'h0, req_ready}, 64'h0);
            chk("bp_psel", {63'h0, psel}, 64'h0);
        end
        rsp_ready = 1'b1;
        // The waiting request is taken only once back in IDLE.
        do_xfer("bp_next", 32'h0006_0000, 1'b1, 32'h0000_9876, 4'hC, 1, 32'h0, 1'b0);

        // Reset mid-ACCESS: transfer discarded, outputs back to reset values.
        @(negedge clk);
        chk("rs_req_ready", {63'h0, req_ready}, 64'h1);
        req_valid = 1'b1; req_addr = 32'h0007_0000; req_write = 1'b1;
        req_wdata = 32'h0000_55AA; req_strb = 4'h3; pready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rs_access_penable", {63'h0, penable}, 64'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rs_psel", {63'h0, psel}, 64'h0);
        chk("rs_penable", {63'h0, penable}, 64'h0);
        chk("rs_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("rs_paddr", {32'h0, paddr}, 64'h0);
        chk("rs_pwrite", {63'h0, pwrite}, 64'h0);
        chk("rs_pwdata", {32'h0, pwdata}, 64'h0);
        chk("rs_pstrb", {60'h0, pstrb}, 64'h0);
        chk("rs_req_ready", {63'h0, req_ready}, 64'h1);
        repeat (3) begin
            @(negedge clk);
            chk("rs_no_rsp", {63'h0, rsp_valid}, 64'h0);
            chk("rs_no_psel", {63'h0, psel}, 64'h0);
        end

        // Normal operation after reset.
        do_xfer("post_rst", 32'h0008_0000, 1'b0, 32'h0, 4'h0, 0, 32'h1357_9BDF, 1'b0);
        repeat (2) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
